fsm_experiment: RTL and testbench

FSM_EXPERIMENT -- requirements
Module: fsm_experiment

---
 rtl/fsm_experiment.sv | 117 +++++++++++
 tb/tb_fsm_experiment.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_experiment.sv
// Experiment sequencer: start -> fast-gate delay -> detonation pulse -> debounced
// wire break -> phase-aligned detector trigger -> holdoff until the detector is ready.
module fsm_experiment #(
    parameter int unsigned FG_DELAY     = 400000,
    parameter int unsigned DET_PULSE    = 2000,
    parameter int unsigned DEBOUNCE     = 200,
    parameter int unsigned WIRE_TIMEOUT = 200000,
    parameter int unsigned TRIG_PULSE   = 200,
    parameter int unsigned HOLDOFF      = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_signal,
    input  logic        fg_signal,
    input  logic        phase_signal,
    input  logic        wire_signal,
    input  logic        detector_ready,
    output logic        detonation_signal,
    output logic        output_trigger,
    output logic [2:0]  scenario_state,
    output logic [31:0] counter_out
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARMED      = 3'd1,
        S_WAIT_DELAY = 3'd2,
        S_DETONATE   = 3'd3,
        S_WAIT_WIRE  = 3'd4,
        S_WAIT_PHASE = 3'd5,
        S_TRIGGER    = 3'd6,
        S_DONE       = 3'd7
    } state_t;

    localparam logic [31:0] L_FG_LAST   = 32'(FG_DELAY - 1);
    localparam logic [31:0] L_DET_LAST  = 32'(DET_PULSE - 1);
    localparam logic [31:0] L_DEB_LAST  = 32'(DEBOUNCE - 1);
    localparam logic [31:0] L_WIRE_LAST = 32'(WIRE_TIMEOUT - 1);
    localparam logic [31:0] L_TRIG_LAST = 32'(TRIG_PULSE - 1);
    localparam logic [31:0] L_HOLD_LAST = 32'(HOLDOFF - 1);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [2:0]  r_prev;
    logic [31:0] r_count;
    logic [31:0] r_deb;
    logic        r_det;
    logic        r_trig;

    logic [4:0]  w_async;
    logic [2:0]  w_rise;
    logic        w_wire;
    logic        w_ready;

    // bit order: start, fg, phase, wire, ready
    assign w_async = {detector_ready, wire_signal, phase_signal, fg_signal, start_signal};
    assign w_rise  = r_sync2[2:0] & ~r_prev;
    assign w_wire  = r_sync2[3];
    assign w_ready = r_sync2[4];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[2:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (w_rise[0] && w_ready) w_next = S_ARMED;
            S_ARMED:      if (w_rise[1]) w_next = S_WAIT_DELAY;
            S_WAIT_DELAY: if (r_count == L_FG_LAST) w_next = S_DETONATE;
            S_DETONATE:   if (r_count == L_DET_LAST) w_next = S_WAIT_WIRE;
            S_WAIT_WIRE: begin
                // debounce success takes priority over a coincident timeout
                if (w_wire && (r_deb == L_DEB_LAST)) w_next = S_WAIT_PHASE;
                else if (r_count == L_WIRE_LAST)     w_next = S_IDLE;
            end
            S_WAIT_PHASE: if (w_rise[2]) w_next = S_TRIGGER;
            S_TRIGGER:    if (r_count == L_TRIG_LAST) w_next = S_DONE;
            S_DONE:       if ((r_count >= L_HOLD_LAST) && w_ready) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_deb   <= '0;
            r_det   <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)  r_count <= '0;
            else if (r_count != '1) r_count <= r_count + 32'd1;
            if ((r_state == S_WAIT_WIRE) && w_wire) r_deb <= r_deb + 32'd1;
            else                                    r_deb <= '0;
            r_det  <= (w_next == S_DETONATE);
            r_trig <= (w_next == S_TRIGGER);
        end
    end

    assign detonation_signal = r_det;
    assign output_trigger    = r_trig;
    assign scenario_state    = r_state;
    assign counter_out       = r_count;

endmodule

// File: tb/tb_fsm_experiment.sv
// Directed bench for fsm_experiment using shortened timing parameters.
module tb_fsm_experiment;

    localparam int unsigned P_FG   = 40;
    localparam int unsigned P_DET  = 10;
    localparam int unsigned P_DEB  = 8;
    localparam int unsigned P_WIRE = 60;
    localparam int unsigned P_TRIG = 6;
    localparam int unsigned P_HOLD = 12;

    logic        clock = 1'b0;
    logic        reset, start_signal, fg_signal, phase_signal, wire_signal, detector_ready;
    logic        detonation_signal, output_trigger;
    logic [2:0]  scenario_state;
    logic [31:0] counter_out;

    int n_vec = 0;
    int n_err = 0;

    fsm_experiment #(
        .FG_DELAY(P_FG), .DET_PULSE(P_DET), .DEBOUNCE(P_DEB),
        .WIRE_TIMEOUT(P_WIRE), .TRIG_PULSE(P_TRIG), .HOLDOFF(P_HOLD)
    ) u_dut (
        .clock(clock), .reset(reset), .start_signal(start_signal),
        .fg_signal(fg_signal), .phase_signal(phase_signal),
        .wire_signal(wire_signal), .detector_ready(detector_ready),
        .detonation_signal(detonation_signal), .output_trigger(output_trigger),
        .scenario_state(scenario_state), .counter_out(counter_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // returns tick count until the state is reached, or -1 on timeout
    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (scenario_state != s && n < max) begin
            tick();
            n++;
        end
        if (scenario_state != s) n = -1;
    endtask

    task automatic pulse_start();
        start_signal = 1'b1; ticks(3); start_signal = 1'b0;
    endtask

    task automatic pulse_fg();
        fg_signal = 1'b1; ticks(3); fg_signal = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        int lv [6];
        int ln [6];
        lv = '{1, 0, 1, 0, 1, 0};
        ln = '{3, 2, 5, 1, 2, 3};

        reset = 1'b1; start_signal = 1'b0; fg_signal = 1'b0; phase_signal = 1'b0;
        wire_signal = 1'b0; detector_ready = 1'b1;
        ticks(3);
        chk("rst_state", 32'(scenario_state), 0);
        chk("rst_cnt", counter_out, 0);
        chk("rst_det", 32'(detonation_signal), 0);
        chk("rst_trig", 32'(output_trigger), 0);
        reset = 1'b0;
        tick();
        chk("idle_cnt", counter_out, 1);

        // start while detector busy is ignored
        detector_ready = 1'b0; ticks(3);
        start_signal = 1'b1; ticks(5);
        chk("start_notready", 32'(scenario_state), 0);
        start_signal = 1'b0; detector_ready = 1'b1; ticks(3);

        // fg edge in IDLE is discarded
        fg_signal = 1'b1; ticks(4); fg_signal = 1'b0; ticks(3);

        start_signal = 1'b1; ticks(2);
        chk("start_lat2", 32'(scenario_state), 0);
        tick();
        chk("start_lat3", 32'(scenario_state), 1);
        start_signal = 1'b0; ticks(5);
        chk("stale_fg", 32'(scenario_state), 1);
        start_signal = 1'b1; ticks(5);
        chk("start_armed", 32'(scenario_state), 1);
        start_signal = 1'b0; ticks(2);

        pulse_fg();
        chk("fg_state", 32'(scenario_state), 2);
        chk("fg_cnt", counter_out, 0);
        ticks(P_FG - 1);
        chk("delay_state", 32'(scenario_state), 2);
        chk("delay_det", 32'(detonation_signal), 0);
        chk("delay_cnt", counter_out, P_FG - 1);
        tick();
        chk("det_state", 32'(scenario_state), 3);
        chk("det_on", 32'(detonation_signal), 1);
        n = 1;
        while (n < 100) begin
            tick();
            if (detonation_signal) n++; else break;
        end
        chk("det_width", 32'(n), P_DET);
        chk("wire_state", 32'(scenario_state), 4);

        // bounces shorter than the debounce window
        for (int i = 0; i < 6; i++) begin
            wire_signal = lv[i][0];
            ticks(ln[i]);
        end
        chk("bounce_hold", 32'(scenario_state), 4);
        wire_signal = 1'b1;
        wait_state(3'd5, 100, n);
        chk("deb_latency", 32'(n), P_DEB + 2);
        ticks(5);
        chk("phase_wait", 32'(scenario_state), 5);

        phase_signal = 1'b1; ticks(3);
        chk("trig_state", 32'(scenario_state), 6);
        chk("trig_on", 32'(output_trigger), 1);
        phase_signal = 1'b0;
        n = 1;
        while (n < 100) begin
            tick();
            detector_ready = 1'b0;
            if (output_trigger) n++; else break;
        end
        chk("trig_width", 32'(n), P_TRIG);
        chk("done_state", 32'(scenario_state), 7);
        ticks(30);
        chk("done_hold", 32'(scenario_state), 7);
        detector_ready = 1'b1; ticks(2);
        chk("ready_lat2", 32'(scenario_state), 7);
        tick();
        chk("ready_idle", 32'(scenario_state), 0);

        // wire never breaks: timeout abort
        wire_signal = 1'b0; ticks(3);
        pulse_start();
        chk("run2_armed", 32'(scenario_state), 1);
        pulse_fg();
        wait_state(3'd4, P_FG + P_DET + 20, n);
        chk("run2_wire", 32'(scenario_state), 4);
        n = 0; seen = 0;
        while (scenario_state == 3'd4 && n < P_WIRE + 20) begin
            tick();
            n++;
            if (output_trigger) seen = 1;
        end
        chk("timeout_len", 32'(n), P_WIRE);
        chk("timeout_idle", 32'(scenario_state), 0);
        chk("timeout_notrig", 32'(seen), 0);

        // holdoff with detector always ready
        ticks(3);
        wire_signal = 1'b1;
        pulse_start();
        pulse_fg();
        wait_state(3'd5, P_FG + P_DET + P_DEB + 20, n);
        chk("run3_phase", 32'(scenario_state), 5);
        phase_signal = 1'b1; ticks(3); phase_signal = 1'b0;
        wait_state(3'd7, P_TRIG + 5, n);
        chk("run3_done", 32'(scenario_state), 7);
        wait_state(3'd0, P_HOLD + 20, n);
        chk("holdoff_len", 32'(n), P_HOLD);
        wire_signal = 1'b0;

        // reset mid-detonation
        ticks(3);
        pulse_start();
        pulse_fg();
        wait_state(3'd3, P_FG + 5, n);
        ticks(3);
        chk("run4_det", 32'(detonation_signal), 1);
        reset = 1'b1; tick();
        chk("rstdet_det", 32'(detonation_signal), 0);
        chk("rstdet_state", 32'(scenario_state), 0);
        chk("rstdet_cnt", counter_out, 0);
        reset = 1'b0; ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
